// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction memory + PC sequencer issuing 16-bit words to control_unit
// Optional build macro: IFU_ILLEGAL_TRAP_EN (trap on opcodes 110/111 instead of skipping them)
module instr_fetch_unit #(
  parameter int IMEM_DEPTH     = 8,
  parameter int PC_W           = 3,
  parameter int COMPUTE_CYCLES = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            host_wr_en,
  input  logic [PC_W-1:0] host_wr_addr,
  input  logic [15:0]     host_wr_data,
  input  logic            start,
  output logic [15:0]     instr_out,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(IMEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(COMPUTE_CYCLES - 1);
  localparam logic [2:0] OP_END     = 3'b000;
  localparam logic [2:0] OP_COMPUTE = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_HOLD, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       instr_out_q, instr_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       imem_q [IMEM_DEPTH];
  logic [15:0]       fetch_word;
  logic              fetch_illegal;
  logic              host_window;
  logic              at_last;

  assign fetch_word    = imem_q[pc_q];
  assign fetch_illegal = (fetch_word[15:14] == 2'b11);
  assign host_window   = (state_q == S_IDLE) || (state_q == S_HALT);
  assign at_last       = (pc_q == LAST_PC);

  // Instruction memory: host writes only land while the sequencer is parked; contents survive reset
  always_ff @(posedge clk) begin
    if (host_wr_en && host_window) begin
      imem_q[host_wr_addr] <= host_wr_data;
    end
  end

`ifdef IFU_ILLEGAL_TRAP_EN
  logic error_q, error_d;
`endif

  // Next-state and datapath updates for the fetch/issue/hold sequencer
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_out_d = instr_out_q;
    cnt_d       = cnt_q;
`ifdef IFU_ILLEGAL_TRAP_EN
    error_d     = error_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
`ifdef IFU_ILLEGAL_TRAP_EN
          error_d = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (fetch_illegal) begin
`ifdef IFU_ILLEGAL_TRAP_EN
          state_d = S_HALT;
          error_d = 1'b1;
`else
          if (at_last) state_d = S_HALT;
          else         pc_d    = pc_q + PC_W'(1);
`endif
        end else begin
          instr_out_d = fetch_word;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          instr_out_d = '0;
          if (instr_out_q[15:13] == OP_END) begin
            state_d = S_HALT;
          end else if (instr_out_q[15:13] == OP_COMPUTE) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_MAX;
          end else if (at_last) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (at_last) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset so instr_valid drops immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_out_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_out_q <= instr_out_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef IFU_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared by the next start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign instr_out   = instr_out_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign pc          = pc_q;
  assign busy        = !host_window;
  assign done        = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam int DEPTH = 8;
  localparam int PCW   = 3;
  localparam int CC    = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           host_wr_en;
  logic [PCW-1:0] host_wr_addr;
  logic [15:0]    host_wr_data;
  logic           start;
  logic [15:0]    instr_out;
  logic           instr_valid;
  logic           instr_ready;
  logic [PCW-1:0] pc;
  logic           busy;
  logic           done;
  logic           error_o;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .PC_W(PCW), .COMPUTE_CYCLES(CC)) dut (
    .clk(clk), .reset(reset),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .start(start),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .busy(busy), .done(done), .error(error_o)
  );

  always #5 clk = ~clk;

  // Reference model state: what the memory holds and what the run should produce
  logic [15:0] prog [DEPTH];
  logic [15:0] exp_iss [$];
  int          exp_gap [$];
  int          exp_pc;
  bit          exp_err;

  typedef struct {
    logic [7:0][15:0] words;
    int               n_iss;
    int               fpc;
    bit               ferr;
  } vec_t;

  vec_t tv [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Walk the program by the architectural rules: issued words in order, and the number of
  // cycles from the previous handshake (or start) to each word's valid.
  function automatic void model();
    int a = 0;
    int extra = 0;
    logic [2:0] op;
    exp_iss.delete();
    exp_gap.delete();
    exp_err = 0;
    while (1) begin
      op = prog[a][15:13];
      if (op >= 3'd6) begin
`ifdef IFU_ILLEGAL_TRAP_EN
        exp_err = 1;
        exp_pc  = a;
        return;
`else
        extra++;
        if (a == DEPTH - 1) begin exp_pc = a; return; end
        a++;
        continue;
`endif
      end
      exp_iss.push_back(prog[a]);
      exp_gap.push_back(2 + extra);
      extra = 0;
      if (op == 3'd0) begin exp_pc = a; return; end
      if (op == 3'd4) extra = CC;
      if (a == DEPTH - 1) begin exp_pc = a; return; end
      a++;
    end
  endfunction

  task automatic load_prog(input logic [7:0][15:0] w);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      host_wr_en   = 1'b1;
      host_wr_addr = PCW'(i);
      host_wr_data = w[i];
      prog[i]      = w[i];
    end
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  // mode 0: ready always high; 1: random ready; 2: hold ready low 5 cycles on 0x201E
  task automatic run_prog(input int mode, input bit wr_with_start,
                          input logic [PCW-1:0] wa, input logic [15:0] wd, input string name);
    int  cyc, last_hs, n_hs, stall;
    bit  pend;
    logic [15:0] prev_out;
    if (wr_with_start) prog[wa] = wd;
    model();
    @(negedge clk);
    start = 1'b1;
    if (wr_with_start) begin
      host_wr_en = 1'b1; host_wr_addr = wa; host_wr_data = wd;
    end
    @(negedge clk);
    start = 1'b0; host_wr_en = 1'b0;
    cyc = 1; last_hs = 0; n_hs = 0; stall = 0; pend = 0; prev_out = '0;
    while (!done && cyc < 600) begin
      case (mode)
        0: instr_ready = 1'b1;
        1: instr_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (instr_valid && instr_out == 16'h201E && stall < 5) begin
            instr_ready = 1'b0;
            stall++;
            check({name, " stall_pc"}, 32'(pc), 32'd2);
          end else begin
            instr_ready = 1'b1;
          end
        end
      endcase
      check({name, " busy"}, 32'(busy), 32'd1);
      if (!instr_valid) check({name, " out_zero"}, 32'(instr_out), 32'd0);
      if (pend) begin
        check({name, " hold_valid"}, 32'(instr_valid), 32'd1);
        check({name, " hold_data"}, 32'(instr_out), 32'(prev_out));
      end
      if (instr_valid && !pend && n_hs < exp_gap.size())
        check({name, " gap"}, 32'(cyc - last_hs), 32'(exp_gap[n_hs]));
      if (instr_valid && instr_ready) begin
        if (n_hs < exp_iss.size()) check({name, " word"}, 32'(instr_out), 32'(exp_iss[n_hs]));
        else check({name, " extra_issue"}, 32'(n_hs), 32'(exp_iss.size()));
        n_hs++;
        last_hs = cyc;
      end
      pend     = instr_valid && !instr_ready;
      prev_out = instr_out;
      @(negedge clk);
      cyc++;
    end
    instr_ready = 1'b0;
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " n_issued"}, 32'(n_hs), 32'(exp_iss.size()));
    check({name, " pc"}, 32'(pc), 32'(exp_pc));
    check({name, " error"}, 32'(error_o), 32'(exp_err));
    check({name, " busy_end"}, 32'(busy), 32'd0);
    check({name, " valid_end"}, 32'(instr_valid), 32'd0);
    if (mode == 2) check({name, " stall_cycles"}, 32'(stall), 32'd5);
  endtask

  initial begin
    reset = 1'b1; host_wr_en = 0; host_wr_addr = '0; host_wr_data = '0;
    start = 0; instr_ready = 0;

    // Directed programs, word 7 written first in each concatenation
    tv[0] = '{ {16'h0000,16'hA000,16'h2007,16'h8000,16'h6000,16'h201E,16'h4000,16'h200F}, 8, 7, 0 };
`ifdef IFU_ILLEGAL_TRAP_EN
    tv[1] = '{ {16'h0000,16'hA000,16'h2007,16'h8000,16'h6000,16'hC000,16'h4000,16'h200F}, 2, 2, 1 };
    tv[5] = '{ {16'hE000,16'h4000,16'h4000,16'h4000,16'h4000,16'h4000,16'h4000,16'h4000}, 7, 7, 1 };
`else
    tv[1] = '{ {16'h0000,16'hA000,16'h2007,16'h8000,16'h6000,16'hC000,16'h4000,16'h200F}, 7, 7, 0 };
    tv[5] = '{ {16'hE000,16'h4000,16'h4000,16'h4000,16'h4000,16'h4000,16'h4000,16'h4000}, 7, 7, 0 };
`endif
    tv[2] = '{ {16'h2007,16'h2006,16'h2005,16'h2004,16'h2003,16'h2002,16'h2001,16'h2000}, 8, 7, 0 };
    tv[3] = '{ {16'h2000,16'h2000,16'h2000,16'h2000,16'h2000,16'h2000,16'h2000,16'h0000}, 1, 0, 0 };
    tv[4] = '{ {16'h8000,16'h2000,16'h2000,16'h2000,16'h2000,16'h2000,16'h2000,16'h2000}, 8, 7, 0 };

    @(negedge clk);
    check("rst valid", 32'(instr_valid), 0);
    check("rst out",   32'(instr_out), 0);
    check("rst pc",    32'(pc), 0);
    check("rst busy",  32'(busy), 0);
    check("rst done",  32'(done), 0);
    check("rst error", 32'(error_o), 0);
    reset = 1'b0;

    for (int t = 0; t < 6; t++) begin
      load_prog(tv[t].words);
      run_prog(0, 0, '0, '0, $sformatf("tv%0d", t));
      check($sformatf("tv%0d tbl_pc", t), 32'(pc), 32'(tv[t].fpc));
      check($sformatf("tv%0d tbl_n", t), 32'(exp_iss.size()), 32'(tv[t].n_iss));
      check($sformatf("tv%0d tbl_err", t), 32'(error_o), 32'(tv[t].ferr));
    end

    // Backpressure on word 2
    load_prog(tv[0].words);
    run_prog(2, 0, '0, '0, "stall");

    // Host write while busy must be dropped
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    check("drop busy", 32'(busy), 1);
    host_wr_en = 1'b1; host_wr_addr = 3'd3; host_wr_data = 16'hFFFF;
    @(negedge clk); host_wr_en = 1'b0;
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check("drop reached_done", 32'(done), 1);
    instr_ready = 1'b0;
    run_prog(0, 0, '0, '0, "rerun");

    // Start coinciding with a write: the written END at word 0 must execute
    run_prog(1, 1, 3'd0, 16'h0000, "wr_start");
    load_prog(tv[0].words);

    // Asynchronous reset while in HOLD
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 100 && !(instr_valid && instr_out[15:13] == 3'b100); i++) @(negedge clk);
    check("hold found_compute", 32'(instr_out[15:13]), 32'd4);
    @(negedge clk); @(negedge clk);
    check("hold busy", 32'(busy), 1);
    check("hold valid", 32'(instr_valid), 0);
    #2 reset = 1'b1;
    #1;
    check("arst valid", 32'(instr_valid), 0);
    check("arst out",   32'(instr_out), 0);
    check("arst pc",    32'(pc), 0);
    check("arst busy",  32'(busy), 0);
    check("arst done",  32'(done), 0);
    @(negedge clk); reset = 1'b0; instr_ready = 1'b0;
    run_prog(0, 0, '0, '0, "after_rst");

    // Randomized programs against the model
    for (int r = 0; r < 20; r++) begin
      logic [7:0][15:0] w;
      for (int i = 0; i < DEPTH; i++) begin
        logic [2:0] op;
        op = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        w[i] = {op, 13'($urandom)};
      end
      load_prog(w);
      run_prog(1, 0, '0, '0, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
